// File: rtl/fsk_bit_timer.sv
// fsk_bit_timer: paces valid/ready data bits into DDS tuning words, one bit per programmed period.
// Handshake-to-tune latency 1 cycle; Bit_Ready only at bit boundaries. Macro FSK_IDLE_MARK_EN drives Freq1 when no bit is active.
module fsk_bit_timer #(
  parameter int W = 42
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic [W-1:0] Period,
  input  logic [W-1:0] Freq0,
  input  logic [W-1:0] Freq1,
  input  logic         Start,
  input  logic         Stop,
  input  logic         Bit_Data,
  input  logic         Bit_Valid,
  output logic         Bit_Ready,
  output logic [W-1:0] Tune_Word,
  output logic         Bit_Strobe,
  output logic         Busy,
  output logic         Underrun
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_RUN   = 2'd2
  } state_t;

  state_t       r_state;
  state_t       w_state_nxt;
  logic [W-1:0] r_per;
  logic [W-1:0] w_per_nxt;
  logic [W-1:0] r_cnt;
  logic [W-1:0] w_cnt_nxt;
  logic [W-1:0] r_tune;
  logic [W-1:0] w_tune_nxt;
  logic [W-1:0] w_idle_tune;
  logic [W-1:0] w_gap_tune;
  logic         r_stop_pend;
  logic         w_stop_nxt;
  logic         r_underrun;
  logic         w_unr_nxt;
  logic         r_strobe;
  logic         w_ready;
  logic         w_hs;
  logic         w_last;

`ifdef FSK_IDLE_MARK_EN
  assign w_idle_tune = Freq1;
  assign w_gap_tune  = Freq1;
`else
  assign w_idle_tune = '0;
  assign w_gap_tune  = r_tune;
`endif

  assign w_last = (r_cnt == '0);
  assign w_hs   = w_ready & Bit_Valid;

  always_comb begin
    w_state_nxt = r_state;
    w_per_nxt   = r_per;
    w_cnt_nxt   = r_cnt;
    w_tune_nxt  = r_tune;
    w_stop_nxt  = r_stop_pend;
    w_unr_nxt   = r_underrun;
    w_ready     = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_tune_nxt = w_idle_tune;
        w_stop_nxt = 1'b0;
        w_cnt_nxt  = '0;
        if (Start) begin
          w_per_nxt   = (Period == '0) ? W'(1) : Period;
          w_unr_nxt   = 1'b0;
          w_state_nxt = S_FETCH;
        end
      end
      S_FETCH: begin
        w_ready    = 1'b1;
        w_tune_nxt = w_gap_tune;
        if (Bit_Valid) begin
          w_state_nxt = S_RUN;
        end else if (Stop) begin
          w_tune_nxt  = w_idle_tune;
          w_state_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        if (!w_last) begin
          w_cnt_nxt = r_cnt - W'(1);
          if (Stop) w_stop_nxt = 1'b1;
        end else if (r_stop_pend || Stop) begin
          // Stop outranks a waiting bit at the boundary
          w_stop_nxt  = 1'b0;
          w_tune_nxt  = w_idle_tune;
          w_state_nxt = S_IDLE;
        end else begin
          w_ready = 1'b1;
          if (!Bit_Valid) begin
            w_unr_nxt   = 1'b1;
            w_tune_nxt  = w_gap_tune;
            w_state_nxt = S_FETCH;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    if (w_hs) begin
      w_tune_nxt  = Bit_Data ? Freq1 : Freq0;
      w_cnt_nxt   = r_per - W'(1);
      w_state_nxt = S_RUN;
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      r_state     <= S_IDLE;
      r_per       <= W'(1);
      r_cnt       <= '0;
      r_tune      <= '0;
      r_stop_pend <= 1'b0;
      r_underrun  <= 1'b0;
      r_strobe    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_per       <= w_per_nxt;
      r_cnt       <= w_cnt_nxt;
      r_tune      <= w_tune_nxt;
      r_stop_pend <= w_stop_nxt;
      r_underrun  <= w_unr_nxt;
      r_strobe    <= w_hs;
    end
  end

  assign Bit_Ready  = w_ready;
  assign Tune_Word  = r_tune;
  assign Bit_Strobe = r_strobe;
  assign Busy       = (r_state != S_IDLE);
  assign Underrun   = r_underrun;

endmodule
